uart_tx_core: RTL
=================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 234, meaning clk cycles per UART bit period (legal range 2..65535).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits per frame (legal values 1 or 2).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable_tx  input  1  start request; sampled on posedge clk.
REQ-006 tx_data  input  8  byte to send; sampled only when enable_tx is accepted.
REQ-007 uart_tx  output  1  serial line; idles high.
REQ-008 busy  output  1  high from acceptance until the frame completes.
REQ-009 tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL accept enable_tx only when busy=0; enable_tx while busy=1 SHALL be ignored with no queuing.
REQ-011 On acceptance, SHALL latch tx_data into an internal shift register, set busy=1 on the next edge, and drive uart_tx=0 (start bit) from that same edge.
REQ-012 SHALL run FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, each bit lasting exactly BAUD_DIV cycles.
REQ-013 DATA SHALL send 8 bits LSB first, using a 3-bit index that advances at each bit-period end; DATA -> next state occurs after index 7 completes.
REQ-014 STOP SHALL drive uart_tx=1 for STOP_BITS*BAUD_DIV cycles.
REQ-015 The bit-period counter SHALL count 0..BAUD_DIV-1, be cleared on acceptance, and wrap to 0 at each bit boundary.
REQ-016 tx_done SHALL pulse high for exactly one cycle on the last cycle of STOP, with busy=1 in that same cycle; busy SHALL be 0 on the following edge.
REQ-017 enable_tx asserted in the cycle tx_done=1 SHALL be ignored; it is accepted from the first cycle with busy=0, so back-to-back frames are separated by exactly one idle-high cycle.
REQ-018 Total frame length SHALL be (10 + STOP_BITS - 1 + P)*BAUD_DIV cycles, where P=1 with parity and 0 without.
REQ-019 Changes to tx_data while busy=1 SHALL NOT affect the frame in progress.

Reset
REQ-020 While rst=1, outputs SHALL be uart_tx=1, busy=0, tx_done=0, FSM=IDLE, and counters=0, regardless of clk.
REQ-021 rst asserted mid-frame SHALL abort the frame immediately with no tx_done pulse; after deassertion, the first accepted enable_tx SHALL start a fresh frame.

Configuration
REQ-022 Macro UART_TX_PARITY_EN, when defined, SHALL insert the PARITY state after DATA, driving even parity (XOR of the 8 data bits) for one bit period.
REQ-023 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP (8N1/8N2 framing).

Structure
REQ-024 Shared package uart_pkg SHALL hold the FSM state typedef (IDLE, START, DATA, PARITY, STOP), UART_DATA_W=8, and the idle-line level constant.
REQ-025 Sub-module uart_baud_gen SHALL contain the BAUD_DIV counter, with inputs clk, rst and clear, and output tick pulsing on each bit-period end.

Verification (BAUD_DIV=4, STOP_BITS=1 unless stated)
REQ-026 rst then enable_tx=1 for 1 cycle with tx_data=8'h55 -> uart_tx holds 0,1,0,1,0,1,0,1,0,1 for 4 cycles each, then tx_done pulses once at cycle 40 with busy falling at cycle 41.
REQ-027 enable_tx pulsed with 8'hA3, then again at cycle 10 with 8'hFF -> only 8'hA3 is transmitted, exactly one tx_done pulse, and uart_tx stays 1 after the frame.
REQ-028 enable_tx held high continuously with 8'h00 -> consecutive frames, each start bit beginning exactly one cycle after the previous tx_done.
REQ-029 rst asserted at cycle 17 of a frame -> uart_tx=1 and busy=0 immediately, no tx_done; a following 8'h41 request sends a correct full frame.
REQ-030 UART_TX_PARITY_EN defined, 8'h07 -> parity bit=1 and frame=44 cycles; 8'h03 -> parity bit=0.
REQ-031 STOP_BITS=2, 8'h80 -> stop-high period is 8 cycles and tx_done fires at cycle 44.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
// Purpose: FSM state encoding, data width and idle line level used by uart_tx_core.
// Ports: none (package).
package uart_pkg;

  localparam int   UART_DATA_W   = 8;
  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter for the UART transmitter
// Purpose: counts 0..BAUD_DIV-1 and flags the last cycle of each bit period.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   clear - hold counter at 0 (asserted while the transmitter is idle)
//   tick  - high on the last cycle of a bit period
module uart_baud_gen #(
  parameter int BAUD_DIV = 234
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == 16'(BAUD_DIV - 1));
    cnt_d = cnt_q + 16'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8-bit UART transmitter, 8N1/8N2 or 8E1/8E2 framing
// Purpose: serialises one byte per accepted request, LSB first.
// Build option: define UART_TX_PARITY_EN to add an even parity bit after the data.
// Ports:
//   clk       - clock
//   rst       - asynchronous active-high reset
//   enable_tx - start request, accepted only while busy=0
//   tx_data   - byte captured on acceptance
//   uart_tx   - serial output, idles high
//   busy      - frame in progress
//   tx_done   - one-cycle pulse on the last cycle of the frame
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 234,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_tx,
  input  logic [UART_DATA_W-1:0] tx_data,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   tx_done
);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   tx_q, tx_d;
  logic                   tick;
  logic                   last_stop;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  // With one stop bit the first stop period is already the last one.
  assign last_stop = (STOP_BITS == 1) || stop_idx_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    busy       = (state_q != IDLE);
    tx_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_tx) begin
          state_d    = START;
          shift_d    = tx_data;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (last_stop) begin
            tx_done = 1'b1;
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is registered from the next state so uart_tx is glitch-free
  // and changes on the same edge as the state.
  always_comb begin
    tx_d = UART_IDLE_LVL;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign uart_tx = tx_q;

endmodule
